// File: rtl/seq_shifter_pkg.sv
// Shared definitions for the multi-cycle shift/rotate unit: operation codes and FSM states.
package shifter_pkg;

    localparam logic [1:0] MODE_SLL = 2'b00;
    localparam logic [1:0] MODE_SRL = 2'b01;
    localparam logic [1:0] MODE_SRA = 2'b10;
    localparam logic [1:0] MODE_ROL = 2'b11;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

endpackage

// File: rtl/seq_shifter_stage.sv
// One combinational shift step of k bits (k <= STEP), plus the last bit that leaves the word.
module shift_stage
    import shifter_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int STEP  = 1
) (
    input  logic [WIDTH-1:0]           word,
    input  logic [$clog2(STEP+1)-1:0]  k,
    input  logic [1:0]                 mode,
    input  logic                       sign,
    output logic [WIDTH-1:0]           shifted,
    output logic                       out_bit
);

    localparam int KW = $clog2(STEP + 1);
    localparam int IW = $clog2(WIDTH) + 1;

    logic [IW-1:0]    inv_k;
    logic [WIDTH-1:0] rot_l;
    logic [WIDTH-1:0] lo_bits;
    logic [WIDTH-1:0] fill_mask;

    always_comb begin
        // NOTE: every output gets a default before the case so no path leaves it unassigned (no latch).
        shifted   = word;
        out_bit   = 1'b0;
        inv_k     = IW'(WIDTH) - IW'(k);
        rot_l     = (word << k) | (word >> inv_k);
        lo_bits   = word >> (k - KW'(1));
        fill_mask = ~({WIDTH{1'b1}} >> k);

        // Bit 0 of the rotated word is word[WIDTH-k], the last bit pushed out on the left.
        case (mode)
            MODE_SLL: begin
                shifted = word << k;
                out_bit = rot_l[0];
            end
            MODE_SRL: begin
                shifted = word >> k;
                out_bit = lo_bits[0];
            end
            MODE_SRA: begin
                shifted = (word >> k) | (sign ? fill_mask : '0);
                out_bit = lo_bits[0];
            end
            default: begin
                shifted = rot_l;
                out_bit = rot_l[0];
            end
        endcase
    end

endmodule

// File: rtl/seq_shifter.sv
// Multi-cycle shift/rotate unit: up to STEP bits per clock, valid/ready on operand and result.
module seq_shifter
    import shifter_pkg::*;
#(
    parameter int WIDTH   = 32,
    parameter int SHAMT_W = $clog2(WIDTH),
    parameter int STEP    = 1
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start_valid,
    output logic               start_ready,
    input  logic [WIDTH-1:0]   value,
    input  logic [SHAMT_W-1:0] shamt,
    input  logic [1:0]         mode,
    output logic [WIDTH-1:0]   result,
    output logic               carry_out,
    output logic               result_valid,
    input  logic               result_ready,
    output logic               busy
);

    localparam int KW = $clog2(STEP + 1);

    state_t             state;
    logic [WIDTH-1:0]   work;
    logic               carry;
    logic [SHAMT_W-1:0] rem;
    logic [1:0]         mode_q;
    logic               sign_q;

    logic [KW-1:0]      k;
    logic [SHAMT_W-1:0] rem_next;
    logic [WIDTH-1:0]   shifted;
    logic               step_out;

    always_comb begin
        if (int'(rem) >= STEP) k = KW'(STEP);
        else                   k = KW'(rem);
        rem_next = rem - SHAMT_W'(k);
    end

    shift_stage #(
        .WIDTH (WIDTH),
        .STEP  (STEP)
    ) u_stage (
        .word    (work),
        .k       (k),
        .mode    (mode_q),
        .sign    (sign_q),
        .shifted (shifted),
        .out_bit (step_out)
    );

    always_ff @(posedge clk) begin
        // NOTE: state is updated with <= only, so every register sees pre-edge values of the others.
        if (reset) begin
            state  <= IDLE;
            work   <= '0;
            carry  <= 1'b0;
            rem    <= '0;
            mode_q <= MODE_SLL;
            sign_q <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start_valid) begin
                        work   <= value;
                        mode_q <= mode;
                        rem    <= shamt;
                        sign_q <= value[WIDTH-1];
                        carry  <= 1'b0;
                        state  <= (shamt == '0) ? DONE : SHIFT;
                    end
                end
                SHIFT: begin
                    work  <= shifted;
                    carry <= step_out;
                    rem   <= rem_next;
                    if (rem_next == '0) state <= DONE;
                end
                DONE: begin
                    // A start request here is deliberately dropped; it must be re-presented in IDLE.
                    if (result_ready) state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign start_ready  = (state == IDLE);
    assign busy         = (state != IDLE);
    assign result_valid = (state == DONE);
    assign result       = work;
    assign carry_out    = carry;

endmodule
